// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM state. BURST means a producer currently owns the write port.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width for n requesters. Never returns zero, so a 1-producer
  // configuration still has a legal vector width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request strictly after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Walk candidates from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single FIFO_Buffer write port among N_REQ producers using
// round-robin grants with bounded bursts. A write never happens while the
// FIFO reports full.
//
// Handshake: a word of producer i moves on a cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is only raised for the granted
// producer, and only when the arbiter is enabled and the FIFO is not full.
// Producers hold valid and data stable until they see ready.
//
// Optional macro FIFO_ARB_PRIO_EN: producer 0 wins every IDLE arbitration
// it takes part in, and its releases leave the round-robin pointer alone.
// The busy output mirrors the FSM state (BURST) for observation.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_en,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [idx_w(N_REQ)-1:0]     grant_id,
  output logic                        busy
);

  localparam int IDX_W  = idx_w(N_REQ);
  localparam int BCNT_W = $clog2(BURST_MAX + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_MAX - 1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   grant_nx;
  logic [IDX_W-1:0]   rr_ptr, ptr_nx;
  logic [BCNT_W-1:0]  beat_cnt, beat_nx;
  logic               cur_valid;
  logic               xfer;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cur_valid    = req_valid[grant_id];
  assign busy         = (state == BURST);
  assign xfer         = busy & en & cur_valid & ~fifo_full;
  assign fifo_wr      = xfer;
  assign fifo_en      = en;
  assign fifo_data_in = req_data[grant_id*DATA_W +: DATA_W];

  // Only the granted producer can see ready, and only on a real transfer.
  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = xfer;
  end

  // Next-state logic: grant in IDLE, count beats and release in BURST.
  always_comb begin
    state_nx = state;
    grant_nx = grant_id;
    beat_nx  = beat_cnt;
    ptr_nx   = rr_ptr;
    case (state)
      IDLE: begin
        if (en && pick_found) begin
`ifdef FIFO_ARB_PRIO_EN
          grant_nx = req_valid[0] ? '0 : pick_idx;
`else
          grant_nx = pick_idx;
`endif
          beat_nx  = '0;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (xfer) beat_nx = beat_cnt + 1'b1;
        // Full or disabled stalls the burst; a dropped valid ends it.
        if ((xfer && beat_cnt == LAST_BEAT) || !cur_valid) begin
          state_nx = IDLE;
`ifdef FIFO_ARB_PRIO_EN
          if (grant_id != '0) ptr_nx = grant_id;
`else
          ptr_nx = grant_id;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= IDX_W'(N_REQ - 1);
    end else begin
      state    <= state_nx;
      grant_id <= grant_nx;
      beat_cnt <= beat_nx;
      rr_ptr   <= ptr_nx;
    end
  end

endmodule
